// File: rtl/cmd_gen.sv
// cmd_gen: host-side command transmitter for the accelerator command interface.
// Accepts one job descriptor (size plus W/X/R buffer addresses) on a valid/ready
// port, then issues the five-command sequence SIZE, ADDRW, ADDRX, ADDRR, INITIATE
// as custom-opcode instructions on a valid/ready command port.
//
// Ports:
//   clk                clock, all state on rising edge
//   reset              asynchronous active-low reset
//   job_valid_i        job descriptor valid
//   job_ready_o        block can accept a job (IDLE only)
//   job_size_i         transfer size, must be non-zero
//   job_addr_w_i       W buffer address
//   job_addr_x_i       X buffer address
//   job_addr_r_i       result buffer address
//   cmd_valid_o        command valid
//   cmd_ready_i        decoder accepts command
//   cmd_inst_funct_o   command code
//   cmd_inst_opcode_o  instruction opcode (constant OPCODE)
//   cmd_rs1_o          rs1 register index (constant RS1_IDX)
//   cmd_rs1_data_o     command operand
//   busy_o             sequence in progress
//   done_o             one-cycle pulse: sequence completed
//   err_o              one-cycle pulse: zero-size job rejected
//   jobs_sent_o        completed job count, wraps
module cmd_gen #(
   parameter int unsigned XLEN    = 64,
   parameter logic [6:0]  OPCODE  = 7'b000_1011,
   parameter logic [4:0]  RS1_IDX = 5'd10,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             job_valid_i,
   output logic             job_ready_o,
   input  logic [XLEN-1:0]  job_size_i,
   input  logic [XLEN-1:0]  job_addr_w_i,
   input  logic [XLEN-1:0]  job_addr_x_i,
   input  logic [XLEN-1:0]  job_addr_r_i,
   output logic             cmd_valid_o,
   input  logic             cmd_ready_i,
   output logic [6:0]       cmd_inst_funct_o,
   output logic [6:0]       cmd_inst_opcode_o,
   output logic [4:0]       cmd_rs1_o,
   output logic [XLEN-1:0]  cmd_rs1_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] jobs_sent_o
);

   localparam logic [6:0] F_INIT  = 7'h01;
   localparam logic [6:0] F_SIZE  = 7'h02;
   localparam logic [6:0] F_ADDRW = 7'h04;
   localparam logic [6:0] F_ADDRX = 7'h06;
   localparam logic [6:0] F_ADDRR = 7'h08;

   typedef enum logic [2:0] {
      IDLE,
      SIZE,
      ADDRW,
      ADDRX,
      ADDRR,
      INIT
   } state_t;

   state_t            state, state_nxt;
   logic [XLEN-1:0]   size_q, addr_w_q, addr_x_q, addr_r_q;
   logic              done_q, err_q;
   logic [CNT_W-1:0]  jobs_q;
   logic              job_fire;
   logic              init_fire;

   assign cmd_inst_opcode_o = OPCODE;
   assign cmd_rs1_o         = RS1_IDX;
   assign done_o            = done_q;
   assign err_o             = err_q;
   assign jobs_sent_o       = jobs_q;

   assign job_fire  = job_valid_i && (state == IDLE);
   assign init_fire = (state == INIT) && cmd_ready_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Command outputs are decoded from the registered state and latched job
   // fields, so they stay stable under backpressure without extra holding regs.
   always_comb begin
      state_nxt        = state;
      job_ready_o      = 1'b0;
      cmd_valid_o      = 1'b0;
      busy_o           = 1'b1;
      cmd_inst_funct_o = '0;
      cmd_rs1_data_o   = '0;
      case (state)
         IDLE: begin
            job_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (job_valid_i && (job_size_i != '0)) begin
               state_nxt = SIZE;
            end
         end
         SIZE: begin
            cmd_valid_o      = 1'b1;
            cmd_inst_funct_o = F_SIZE;
            cmd_rs1_data_o   = size_q;
            if (cmd_ready_i) state_nxt = ADDRW;
         end
         ADDRW: begin
            cmd_valid_o      = 1'b1;
            cmd_inst_funct_o = F_ADDRW;
            cmd_rs1_data_o   = addr_w_q;
            if (cmd_ready_i) state_nxt = ADDRX;
         end
         ADDRX: begin
            cmd_valid_o      = 1'b1;
            cmd_inst_funct_o = F_ADDRX;
            cmd_rs1_data_o   = addr_x_q;
            if (cmd_ready_i) state_nxt = ADDRR;
         end
         ADDRR: begin
            cmd_valid_o      = 1'b1;
            cmd_inst_funct_o = F_ADDRR;
            cmd_rs1_data_o   = addr_r_q;
            if (cmd_ready_i) state_nxt = INIT;
         end
         INIT: begin
            cmd_valid_o      = 1'b1;
            cmd_inst_funct_o = F_INIT;
            if (cmd_ready_i) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            busy_o    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         size_q   <= '0;
         addr_w_q <= '0;
         addr_x_q <= '0;
         addr_r_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         jobs_q   <= '0;
      end else begin
         if (job_fire) begin
            size_q   <= job_size_i;
            addr_w_q <= job_addr_w_i;
            addr_x_q <= job_addr_x_i;
            addr_r_q <= job_addr_r_i;
         end
         err_q  <= job_fire && (job_size_i == '0);
         done_q <= init_fire;
         if (init_fire) begin
            jobs_q <= jobs_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cmd_gen.sv
module tb_cmd_gen;

   logic        clk;
   logic        reset;
   logic        job_valid_i;
   logic        job_ready_o;
   logic [63:0] job_size_i, job_addr_w_i, job_addr_x_i, job_addr_r_i;
   logic        cmd_valid_o;
   logic        cmd_ready_i;
   logic [6:0]  cmd_inst_funct_o, cmd_inst_opcode_o;
   logic [4:0]  cmd_rs1_o;
   logic [63:0] cmd_rs1_data_o;
   logic        busy_o, done_o, err_o;
   logic [15:0] jobs_sent_o;

   // narrow-counter instance used only to observe counter wrap
   logic        n_job_ready, n_cmd_valid, n_busy, n_done, n_err;
   logic [6:0]  n_funct, n_opcode;
   logic [4:0]  n_rs1;
   logic [63:0] n_data;
   logic [1:0]  n_jobs;

   cmd_gen #(.XLEN(64), .OPCODE(7'h0B), .RS1_IDX(5'd10), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
      .job_size_i(job_size_i), .job_addr_w_i(job_addr_w_i),
      .job_addr_x_i(job_addr_x_i), .job_addr_r_i(job_addr_r_i),
      .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
      .cmd_inst_funct_o(cmd_inst_funct_o), .cmd_inst_opcode_o(cmd_inst_opcode_o),
      .cmd_rs1_o(cmd_rs1_o), .cmd_rs1_data_o(cmd_rs1_data_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .jobs_sent_o(jobs_sent_o)
   );

   cmd_gen #(.XLEN(64), .OPCODE(7'h0B), .RS1_IDX(5'd10), .CNT_W(2)) dut_w (
      .clk(clk), .reset(reset),
      .job_valid_i(job_valid_i), .job_ready_o(n_job_ready),
      .job_size_i(job_size_i), .job_addr_w_i(job_addr_w_i),
      .job_addr_x_i(job_addr_x_i), .job_addr_r_i(job_addr_r_i),
      .cmd_valid_o(n_cmd_valid), .cmd_ready_i(cmd_ready_i),
      .cmd_inst_funct_o(n_funct), .cmd_inst_opcode_o(n_opcode),
      .cmd_rs1_o(n_rs1), .cmd_rs1_data_o(n_data),
      .busy_o(n_busy), .done_o(n_done), .err_o(n_err),
      .jobs_sent_o(n_jobs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst_n;
      logic        jv;
      logic [63:0] sz, aw, ax, ar;
      logic        cr;
      logic        ev;
      logic [6:0]  ef;
      logic [63:0] ed;
      logic        eb, edn, eer, erd;
      logic [15:0] ej;
   } vec_t;

   function automatic vec_t mk(input logic rst_n, input logic jv,
                               input logic [63:0] sz, input logic [63:0] aw,
                               input logic [63:0] ax, input logic [63:0] ar,
                               input logic cr, input logic ev, input logic [6:0] ef,
                               input logic [63:0] ed, input logic eb, input logic edn,
                               input logic eer, input logic erd, input logic [15:0] ej);
      vec_t v;
      v.rst_n = rst_n; v.jv = jv; v.sz = sz; v.aw = aw; v.ax = ax; v.ar = ar;
      v.cr = cr; v.ev = ev; v.ef = ef; v.ed = ed; v.eb = eb; v.edn = edn;
      v.eer = eer; v.erd = erd; v.ej = ej;
      return v;
   endfunction

   localparam logic [63:0] W = 64'h1000, X = 64'h2000, R = 64'h3000;
   localparam logic [63:0] G = 64'hDEAD_BEEF;

   vec_t vt[22];
   logic [6:0] b2b_exp[13];
   int vcount;

   initial begin
      reset = 1'b0; job_valid_i = 1'b0; cmd_ready_i = 1'b1;
      job_size_i = '0; job_addr_w_i = '0; job_addr_x_i = '0; job_addr_r_i = '0;

      //            rst jv size   aw  ax  ar  cr | vld funct  data    busy done err rdy jobs
      vt[0]  = mk(0, 0, 0,     0,  0,  0,  1,   0, 7'h00, 0,      0, 0, 0, 1, 0);
      vt[1]  = mk(1, 1, 64'h40, W, X,  R,  1,   0, 7'h00, 0,      0, 0, 0, 1, 0);
      vt[2]  = mk(1, 0, 0,     0,  0,  0,  1,   1, 7'h02, 64'h40, 1, 0, 0, 0, 0);
      vt[3]  = mk(1, 0, 0,     0,  0,  0,  1,   1, 7'h04, W,      1, 0, 0, 0, 0);
      vt[4]  = mk(1, 0, 0,     0,  0,  0,  1,   1, 7'h06, X,      1, 0, 0, 0, 0);
      vt[5]  = mk(1, 0, 0,     0,  0,  0,  1,   1, 7'h08, R,      1, 0, 0, 0, 0);
      vt[6]  = mk(1, 0, 0,     0,  0,  0,  1,   1, 7'h01, 0,      1, 0, 0, 0, 0);
      vt[7]  = mk(1, 0, 0,     0,  0,  0,  1,   0, 7'h00, 0,      0, 1, 0, 1, 1);
      // zero-size job
      vt[8]  = mk(1, 1, 0,     W,  X,  R,  1,   0, 7'h00, 0,      0, 0, 0, 1, 1);
      vt[9]  = mk(1, 0, 0,     0,  0,  0,  1,   0, 7'h00, 0,      0, 0, 1, 1, 1);
      vt[10] = mk(1, 0, 0,     0,  0,  0,  1,   0, 7'h00, 0,      0, 0, 0, 1, 1);
      // backpressure during ADDRX, job inputs disturbed while busy
      vt[11] = mk(1, 1, 64'h40, W, X,  R,  1,   0, 7'h00, 0,      0, 0, 0, 1, 1);
      vt[12] = mk(1, 0, G,     G,  G,  G,  1,   1, 7'h02, 64'h40, 1, 0, 0, 0, 1);
      vt[13] = mk(1, 1, G,     G,  G,  G,  1,   1, 7'h04, W,      1, 0, 0, 0, 1);
      vt[14] = mk(1, 0, 0,     0,  0,  0,  0,   1, 7'h06, X,      1, 0, 0, 0, 1);
      vt[15] = mk(1, 0, 0,     0,  0,  0,  0,   1, 7'h06, X,      1, 0, 0, 0, 1);
      vt[16] = mk(1, 0, 0,     0,  0,  0,  0,   1, 7'h06, X,      1, 0, 0, 0, 1);
      vt[17] = mk(1, 0, 0,     0,  0,  0,  1,   1, 7'h06, X,      1, 0, 0, 0, 1);
      vt[18] = mk(1, 0, 0,     0,  0,  0,  1,   1, 7'h08, R,      1, 0, 0, 0, 1);
      vt[19] = mk(1, 0, 0,     0,  0,  0,  1,   1, 7'h01, 0,      1, 0, 0, 0, 1);
      vt[20] = mk(1, 0, 0,     0,  0,  0,  1,   0, 7'h00, 0,      0, 1, 0, 1, 2);
      vt[21] = mk(1, 0, 0,     0,  0,  0,  1,   0, 7'h00, 0,      0, 0, 0, 1, 2);

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         reset = vt[i].rst_n; job_valid_i = vt[i].jv; cmd_ready_i = vt[i].cr;
         job_size_i = vt[i].sz; job_addr_w_i = vt[i].aw;
         job_addr_x_i = vt[i].ax; job_addr_r_i = vt[i].ar;
         #1;
         chk($sformatf("v%0d_valid", i), 64'(cmd_valid_o), 64'(vt[i].ev));
         chk($sformatf("v%0d_funct", i), 64'(cmd_inst_funct_o), 64'(vt[i].ef));
         chk($sformatf("v%0d_data", i), cmd_rs1_data_o, vt[i].ed);
         chk($sformatf("v%0d_busy", i), 64'(busy_o), 64'(vt[i].eb));
         chk($sformatf("v%0d_done", i), 64'(done_o), 64'(vt[i].edn));
         chk($sformatf("v%0d_err", i), 64'(err_o), 64'(vt[i].eer));
         chk($sformatf("v%0d_ready", i), 64'(job_ready_o), 64'(vt[i].erd));
         chk($sformatf("v%0d_jobs", i), 64'(jobs_sent_o), 64'(vt[i].ej));
         chk($sformatf("v%0d_opcode", i), 64'(cmd_inst_opcode_o), 64'h0B);
         chk($sformatf("v%0d_rs1", i), 64'(cmd_rs1_o), 64'd10);
      end

      // back-to-back: job_valid_i held high, second job taken in the done cycle
      b2b_exp = '{7'h00, 7'h02, 7'h04, 7'h06, 7'h08, 7'h01, 7'h00,
                  7'h02, 7'h04, 7'h06, 7'h08, 7'h01, 7'h00};
      vcount = 0;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         cmd_ready_i = 1'b1;
         job_valid_i = (c <= 6);
         job_size_i = 64'h10; job_addr_w_i = 64'hA0; job_addr_x_i = 64'hB0; job_addr_r_i = 64'hC0;
         #1;
         chk($sformatf("b2b%0d_funct", c), 64'(cmd_inst_funct_o), 64'(b2b_exp[c]));
         if (c >= 1 && c <= 11 && cmd_valid_o) vcount++;
         if (c == 6 || c == 12) chk($sformatf("b2b%0d_done", c), 64'(done_o), 64'd1);
      end
      chk("b2b_cmd_count", 64'(vcount), 64'd10);
      chk("b2b_jobs", 64'(jobs_sent_o), 64'd4);
      chk("wrap_jobs_narrow", 64'(n_jobs), 64'd0);

      // abort: reset asserted while ADDRW is on the port
      @(negedge clk);
      job_valid_i = 1'b1; job_size_i = 64'h40;
      job_addr_w_i = W; job_addr_x_i = X; job_addr_r_i = R;
      cmd_ready_i = 1'b0;
      @(negedge clk);
      job_valid_i = 1'b0; cmd_ready_i = 1'b1;
      #1 chk("abort_size_funct", 64'(cmd_inst_funct_o), 64'h02);
      @(negedge clk);
      #1 chk("abort_pre_funct", 64'(cmd_inst_funct_o), 64'h04);
      reset = 1'b0;
      #1;
      chk("abort_valid", 64'(cmd_valid_o), 64'd0);
      chk("abort_busy", 64'(busy_o), 64'd0);
      chk("abort_funct", 64'(cmd_inst_funct_o), 64'd0);
      chk("abort_jobs", 64'(jobs_sent_o), 64'd0);
      @(negedge clk);
      #1 chk("abort_held_valid", 64'(cmd_valid_o), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      job_valid_i = 1'b1; job_size_i = 64'h20;
      job_addr_w_i = 64'h11; job_addr_x_i = 64'h22; job_addr_r_i = 64'h33;
      #1 chk("post_abort_idle", 64'(cmd_valid_o), 64'd0);
      @(negedge clk);
      job_valid_i = 1'b0;
      #1;
      chk("post_abort_funct", 64'(cmd_inst_funct_o), 64'h02);
      chk("post_abort_data", cmd_rs1_data_o, 64'h20);
      for (int c = 0; c < 5; c++) @(negedge clk);
      #1;
      chk("post_abort_done", 64'(done_o), 64'd1);
      chk("post_abort_jobs", 64'(jobs_sent_o), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
